// File: rtl/sar_adc_sequencer.sv
// Multi-channel SAR ADC conversion sequencer with a tick-enabled bit-trial engine.
// Define SAR_AVG_EN to average 2**AVG_LOG2 conversions per channel before each result.
module sar_adc_sequencer #(
    parameter int unsigned RESOLUTION   = 12,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CLK_DIV      = 368,
    parameter int unsigned SETTLE_TICKS = 2,
    parameter int unsigned AVG_LOG2     = 2,
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  start_i,
    input  logic                  cont_i,
    input  logic [CHANNELS-1:0]   ch_mask_i,
    input  logic                  comp_i,
    output logic [RESOLUTION-1:0] dac_o,
    output logic [CW-1:0]         ch_sel_o,
    output logic                  sample_o,
    output logic                  busy_o,
    output logic [RESOLUTION-1:0] data_o,
    output logic [CW-1:0]         data_ch_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam int unsigned BW = $clog2(RESOLUTION);
    localparam int unsigned TW = $clog2(SETTLE_TICKS + 1);

    typedef enum logic [1:0] {StIdle, StSample, StConvert, StStore} state_t;

    state_t                state_q;
    logic [DW-1:0]         div_cnt_q;
    logic [TW-1:0]         tick_cnt_q;
    logic [BW-1:0]         bit_q;
    logic [CHANNELS-1:0]   mask_q;
    logic                  comp_meta_q;
    logic                  comp_sync_q;
    logic                  tick;
    logic                  nxt_found;
    logic [CW-1:0]         nxt_ch;

`ifdef SAR_AVG_EN
    localparam int unsigned AW = RESOLUTION + AVG_LOG2;
    localparam int unsigned NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    logic [AW-1:0]         acc_q;
    logic [NW-1:0]         avg_cnt_q;
    logic [RESOLUTION-1:0] conv_code;
    logic [AW-1:0]         acc_sum;

    // Final code of the running conversion: bit 0 resolves on this tick.
    assign conv_code = {dac_o[RESOLUTION-1:1], comp_sync_q};
    assign acc_sum   = acc_q + AW'(conv_code);
`endif

    assign tick = (div_cnt_q == DW'(CLK_DIV - 1));

    function automatic logic [CW-1:0] lowest(input logic [CHANNELS-1:0] m);
        lowest = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) lowest = CW'(i);
        end
    endfunction

    // Next enabled channel strictly above the one just converted.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_sel_o))) begin
                nxt_found = 1'b1;
                nxt_ch    = CW'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bit_q       <= '0;
            mask_q      <= '0;
            comp_meta_q <= 1'b0;
            comp_sync_q <= 1'b0;
            dac_o       <= '0;
            ch_sel_o    <= '0;
            sample_o    <= 1'b0;
            busy_o      <= 1'b0;
            data_o      <= '0;
            data_ch_o   <= '0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef SAR_AVG_EN
            acc_q       <= '0;
            avg_cnt_q   <= '0;
`endif
        end else begin
            comp_meta_q <= comp_i;
            comp_sync_q <= comp_meta_q;
            div_cnt_q   <= (state_q == StIdle || tick) ? '0 : div_cnt_q + 1'b1;
            if (valid_o && ready_i) valid_o <= 1'b0;

            if (state_q != StIdle && !en_i) begin
                state_q  <= StIdle;
                dac_o    <= '0;
                sample_o <= 1'b0;
                busy_o   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        dac_o <= '0;
                        if ((start_i || cont_i) && en_i && (|ch_mask_i)) begin
                            mask_q     <= ch_mask_i;
                            ch_sel_o   <= lowest(ch_mask_i);
                            state_q    <= StSample;
                            sample_o   <= 1'b1;
                            busy_o     <= 1'b1;
                            tick_cnt_q <= '0;
                            if (start_i) overrun_o <= 1'b0;
`ifdef SAR_AVG_EN
                            acc_q      <= '0;
                            avg_cnt_q  <= '0;
`endif
                        end
                    end
                    StSample: begin
                        if (tick) begin
                            if (tick_cnt_q == TW'(SETTLE_TICKS - 1)) begin
                                state_q  <= StConvert;
                                sample_o <= 1'b0;
                                dac_o    <= RESOLUTION'(1) << (RESOLUTION - 1);
                                bit_q    <= BW'(RESOLUTION - 1);
                            end else begin
                                tick_cnt_q <= tick_cnt_q + 1'b1;
                            end
                        end
                    end
                    StConvert: begin
                        if (tick) begin
                            dac_o[bit_q] <= comp_sync_q;
                            if (bit_q != '0) begin
                                dac_o[bit_q - 1'b1] <= 1'b1;
                                bit_q               <= bit_q - 1'b1;
                            end else begin
`ifdef SAR_AVG_EN
                                acc_q <= acc_sum;
                                if (avg_cnt_q == NW'((1 << AVG_LOG2) - 1)) begin
                                    state_q <= StStore;
                                end else begin
                                    avg_cnt_q  <= avg_cnt_q + 1'b1;
                                    state_q    <= StSample;
                                    sample_o   <= 1'b1;
                                    dac_o      <= '0;
                                    tick_cnt_q <= '0;
                                end
`else
                                state_q <= StStore;
`endif
                            end
                        end
                    end
                    StStore: begin
`ifdef SAR_AVG_EN
                        data_o <= acc_q[AW-1:AVG_LOG2];
`else
                        data_o <= dac_o;
`endif
                        data_ch_o <= ch_sel_o;
                        valid_o   <= 1'b1;
                        if (valid_o && !ready_i) overrun_o <= 1'b1;
                        if (nxt_found || cont_i) begin
                            ch_sel_o   <= nxt_found ? nxt_ch : lowest(mask_q);
                            state_q    <= StSample;
                            sample_o   <= 1'b1;
                            dac_o      <= '0;
                            tick_cnt_q <= '0;
                            div_cnt_q  <= '0;
`ifdef SAR_AVG_EN
                            acc_q      <= '0;
                            avg_cnt_q  <= '0;
`endif
                        end else begin
                            state_q <= StIdle;
                            busy_o  <= 1'b0;
                            dac_o   <= '0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Self-checking bench for sar_adc_sequencer: behavioural comparator plus result scoreboard.
module tb_sar_adc_sequencer;

    localparam int RES = 8;
    localparam int CH  = 4;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic           clk_i     = 1'b0;
    logic           rst_i     = 1'b1;
    logic           en_i      = 1'b1;
    logic           start_i   = 1'b0;
    logic           cont_i    = 1'b0;
    logic [CH-1:0]  ch_mask_i = '0;
    logic           comp_i;
    logic [RES-1:0] dac_o;
    logic [1:0]     ch_sel_o;
    logic           sample_o;
    logic           busy_o;
    logic [RES-1:0] data_o;
    logic [1:0]     data_ch_o;
    logic           valid_o;
    logic           ready_i   = 1'b1;
    logic           overrun_o;

    logic [7:0] vin [CH] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] trials [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    logic [7:0] avg_tbl [4] = '{8'h10, 8'h11, 8'h12, 8'h13};

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   seen;

    sar_adc_sequencer #(
        .RESOLUTION  (RES),
        .CHANNELS    (CH),
        .CLK_DIV     (4),
        .SETTLE_TICKS(1),
        .AVG_LOG2    (2)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .start_i  (start_i),
        .cont_i   (cont_i),
        .ch_mask_i(ch_mask_i),
        .comp_i   (comp_i),
        .dac_o    (dac_o),
        .ch_sel_o (ch_sel_o),
        .sample_o (sample_o),
        .busy_o   (busy_o),
        .data_o   (data_o),
        .data_ch_o(data_ch_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Ideal comparator on the selected input.
    assign comp_i = (vin[ch_sel_o] >= dac_o);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max && busy_o; i++) @(negedge clk_i);
        check_eq(tag, 32'(busy_o), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk_i);
        #1 ready_i = v;
    endtask

    // Each accepted word must match the oldest expected result.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_extra", 32'(sb_q.size()), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("sb_data", 32'(data_o), 32'(mon_e.data));
                check_eq("sb_ch", 32'(data_ch_o), 32'(mon_e.ch));
            end
        end
    end

    initial begin
        // Reset values
        cycles(3);
        check_eq("rst_dac", 32'(dac_o), 0);
        check_eq("rst_ch_sel", 32'(ch_sel_o), 0);
        check_eq("rst_data", 32'(data_o), 0);
        check_eq("rst_data_ch", 32'(data_ch_o), 0);
        check_eq("rst_sample", 32'(sample_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_valid", 32'(valid_o), 0);
        check_eq("rst_overrun", 32'(overrun_o), 0);
        rst_i = 1'b0;

        // Single channel A5: trial sequence and latency
        set_ready(1'b0);
        vin[0] = 8'hA5;
        ch_mask_i = 4'b0001;
        pulse_start();
        for (int n = 1; n <= 37; n++) begin
            @(negedge clk_i);
            if (n >= 4 && n <= 32 && (n % 4) == 0)
                check_eq($sformatf("trial%0d", n / 4 - 1), 32'(dac_o), 32'(trials[n/4-1]));
`ifndef SAR_AVG_EN
            if (n == 36) check_eq("valid_pre", 32'(valid_o), 0);
            if (n == 37) begin
                check_eq("valid_37", 32'(valid_o), 1);
                check_eq("data_37", 32'(data_o), 32'h A5);
                check_eq("data_ch_37", 32'(data_ch_o), 0);
            end
`endif
        end
        wait_idle("a_idle", 800);
        sb_q.push_back('{ch: 2'd0, data: 8'hA5});
        set_ready(1'b1);
        cycles(3);
        check_eq("a_valid_drop", 32'(valid_o), 0);

        // Two-channel scan, ascending order
        vin[1] = 8'h00;
        vin[3] = 8'hFF;
        ch_mask_i = 4'b1010;
        sb_q.push_back('{ch: 2'd1, data: 8'h00});
        sb_q.push_back('{ch: 2'd3, data: 8'hFF});
        pulse_start();
        wait_idle("b_idle", 2000);
        cycles(3);
        check_eq("b_drained", 32'(sb_q.size()), 0);
        check_eq("b_busy", 32'(busy_o), 0);

        // Continuous mode overrun, cleared by idle start
        set_ready(1'b0);
        vin[0] = 8'h3C;
        ch_mask_i = 4'b0001;
        @(negedge clk_i);
        cont_i = 1'b1;
        for (int i = 0; i < 1000 && !valid_o; i++) @(negedge clk_i);
        check_eq("c_first_valid", 32'(valid_o), 1);
        check_eq("c_ovr_first", 32'(overrun_o), 0);
        for (int i = 0; i < 1000 && !overrun_o; i++) @(negedge clk_i);
        check_eq("c_ovr_set", 32'(overrun_o), 1);
        cont_i = 1'b0;
        wait_idle("c_idle", 1000);
        pulse_start();
        check_eq("c_ovr_clr", 32'(overrun_o), 0);
        check_eq("c_busy", 32'(busy_o), 1);
        sb_q.push_back('{ch: 2'd0, data: 8'h3C});
        sb_q.push_back('{ch: 2'd0, data: 8'h3C});
        set_ready(1'b1);
        wait_idle("c_idle2", 1000);
        cycles(3);
        check_eq("c_drained", 32'(sb_q.size()), 0);
        check_eq("c_ovr_final", 32'(overrun_o), 0);

        // Abort mid-CONVERT
        pulse_start();
        cycles(14);
        check_eq("d_busy_pre", 32'(busy_o), 1);
        en_i = 1'b0;
        @(negedge clk_i);
        check_eq("d_dac", 32'(dac_o), 0);
        check_eq("d_busy", 32'(busy_o), 0);
        check_eq("d_sample", 32'(sample_o), 0);
        en_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (valid_o) seen++;
        end
        check_eq("d_no_valid", 32'(seen), 0);

        // Reset mid-SAMPLE with a pending result
        set_ready(1'b0);
        vin[0] = 8'h5A;
        pulse_start();
        wait_idle("e_idle", 1000);
        check_eq("e_valid_pend", 32'(valid_o), 1);
        pulse_start();
        @(negedge clk_i);
        check_eq("e_in_sample", 32'(sample_o), 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_eq("e_dac", 32'(dac_o), 0);
        check_eq("e_ch_sel", 32'(ch_sel_o), 0);
        check_eq("e_data", 32'(data_o), 0);
        check_eq("e_data_ch", 32'(data_ch_o), 0);
        check_eq("e_sample", 32'(sample_o), 0);
        check_eq("e_busy", 32'(busy_o), 0);
        check_eq("e_valid", 32'(valid_o), 0);
        check_eq("e_overrun", 32'(overrun_o), 0);
        set_ready(1'b1);

`ifdef SAR_AVG_EN
        // Four averaged conversions with a moving input
        vin[0] = avg_tbl[0];
        ch_mask_i = 4'b0001;
        sb_q.push_back('{ch: 2'd0, data: 8'h11});
        pulse_start();
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < 200 && sample_o; i++) @(negedge clk_i);
            for (int i = 0; i < 200 && !sample_o; i++) @(negedge clk_i);
            vin[0] = avg_tbl[k];
        end
        wait_idle("f_idle", 1000);
        cycles(3);
        check_eq("f_drained", 32'(sb_q.size()), 0);
`endif

        cycles(2);
        check_eq("sb_final", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
